// File: rtl/mmio_timer.sv
// mmio_timer: memory-mapped machine timer responder.
// Registers: 64-bit mtime, 64-bit mtimecmp, ctrl, sticky status, prescale.
// The optional prescaler is compiled in with `define MMIO_TIMER_PRESCALE_EN;
// without it the timer ticks every cycle while enabled.
module mmio_timer #(
   parameter logic [29:0] BASE_WADDR = 30'h0400_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [29:0] r_addr,
   output logic [31:0] r_val,
   output logic        r_hit,
   input  logic        w_enable,
   input  logic [29:0] w_addr,
   input  logic [31:0] w_val,
   input  logic [3:0]  w_byte_en,
   output logic        irq
);

   localparam logic [2:0] OFF_MTIME_LO = 3'd0;
   localparam logic [2:0] OFF_MTIME_HI = 3'd1;
   localparam logic [2:0] OFF_CMP_LO   = 3'd2;
   localparam logic [2:0] OFF_CMP_HI   = 3'd3;
   localparam logic [2:0] OFF_CTRL     = 3'd4;
   localparam logic [2:0] OFF_STATUS   = 3'd5;
   localparam logic [2:0] OFF_PRESCALE = 3'd6;

   logic [63:0] mtime;
   logic [63:0] mtimecmp;
   logic        ctrl_enable;
   logic        ctrl_irq_en;
   logic        pending;

   logic [29:0] r_off;
   logic [29:0] w_off;
   logic        r_in_win;
   logic        w_in_win;
   logic        wr_any;
   logic        wr_mt_lo, wr_mt_hi, wr_cmp_lo, wr_cmp_hi, wr_ctrl, wr_status;
   logic        tick;
   logic        pend_set;
   logic        w1c;
   logic        pending_nxt;
   logic        enable_nxt;
   logic        irq_en_nxt;
   logic [63:0] mtime_nxt;
   logic [31:0] rd_word;

   // Replace only the byte lanes selected by be.
   function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  be);
      logic [31:0] res;
      for (int i = 0; i < 4; i++)
         res[8*i +: 8] = be[i] ? new_val[8*i +: 8] : old_val[8*i +: 8];
      return res;
   endfunction

   // Window decode: offsets are taken modulo 2^30 so the compare is a single zero test.
   assign r_off    = r_addr - BASE_WADDR;
   assign w_off    = w_addr - BASE_WADDR;
   assign r_in_win = (r_off[29:3] == 27'd0);
   assign w_in_win = (w_off[29:3] == 27'd0);

   // A write with no byte lanes enabled is a complete no-op.
   assign wr_any    = w_enable && w_in_win && (w_byte_en != 4'b0000);
   assign wr_mt_lo  = wr_any && (w_off[2:0] == OFF_MTIME_LO);
   assign wr_mt_hi  = wr_any && (w_off[2:0] == OFF_MTIME_HI);
   assign wr_cmp_lo = wr_any && (w_off[2:0] == OFF_CMP_LO);
   assign wr_cmp_hi = wr_any && (w_off[2:0] == OFF_CMP_HI);
   assign wr_ctrl   = wr_any && (w_off[2:0] == OFF_CTRL);
   assign wr_status = wr_any && (w_off[2:0] == OFF_STATUS);

`ifdef MMIO_TIMER_PRESCALE_EN
   logic [15:0] prescale;
   logic [15:0] presc_cnt;
   logic        wr_presc;
   logic        presc_hit;

   assign wr_presc  = wr_any && (w_off[2:0] == OFF_PRESCALE);
   assign presc_hit = (presc_cnt == prescale);
   assign tick      = ctrl_enable && presc_hit;

   // Prescale divider: counts while enabled and wraps on the tick.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prescale  <= 16'h0;
         presc_cnt <= 16'h0;
      end else begin
         if (ctrl_enable)
            presc_cnt <= presc_hit ? 16'h0 : presc_cnt + 16'd1;
         if (wr_presc)
            prescale <= {w_byte_en[1] ? w_val[15:8] : prescale[15:8],
                         w_byte_en[0] ? w_val[7:0]  : prescale[7:0]};
      end
   end
`else
   assign tick = ctrl_enable;
`endif

   // Register read mux, from current flop values (a same-cycle write is not visible).
   always_comb begin
      rd_word = 32'h0;
      case (r_off[2:0])
         OFF_MTIME_LO: rd_word = mtime[31:0];
         OFF_MTIME_HI: rd_word = mtime[63:32];
         OFF_CMP_LO:   rd_word = mtimecmp[31:0];
         OFF_CMP_HI:   rd_word = mtimecmp[63:32];
         OFF_CTRL:     rd_word = {30'h0, ctrl_irq_en, ctrl_enable};
         OFF_STATUS:   rd_word = {31'h0, pending};
`ifdef MMIO_TIMER_PRESCALE_EN
         OFF_PRESCALE: rd_word = {16'h0, prescale};
`else
         OFF_PRESCALE: rd_word = 32'h0;
`endif
         default:      rd_word = 32'h0;
      endcase
   end

   // Next mtime: a software write to either half suppresses this cycle's tick.
   always_comb begin
      mtime_nxt = mtime;
      if (wr_mt_lo || wr_mt_hi) begin
         if (wr_mt_lo) mtime_nxt[31:0]  = merge_bytes(mtime[31:0], w_val, w_byte_en);
         if (wr_mt_hi) mtime_nxt[63:32] = merge_bytes(mtime[63:32], w_val, w_byte_en);
      end else if (tick) begin
         mtime_nxt = mtime + 64'd1;
      end
   end

   // Next ctrl; only byte lane 0 carries implemented bits.
   always_comb begin
      enable_nxt = ctrl_enable;
      irq_en_nxt = ctrl_irq_en;
      if (wr_ctrl && w_byte_en[0]) begin
         enable_nxt = w_val[0];
         irq_en_nxt = w_val[1];
      end
   end

   // Sticky pending: the compare set beats a write-1-to-clear in the same cycle.
   assign pend_set    = ctrl_enable && (mtime >= mtimecmp);
   assign w1c         = wr_status && w_byte_en[0] && w_val[0];
   assign pending_nxt = pend_set || (pending && !w1c);

   // Timer state, read port and interrupt flops.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mtime       <= 64'h0;
         mtimecmp    <= 64'hFFFF_FFFF_FFFF_FFFF;
         ctrl_enable <= 1'b0;
         ctrl_irq_en <= 1'b0;
         pending     <= 1'b0;
         irq         <= 1'b0;
         r_val       <= 32'h0;
         r_hit       <= 1'b0;
      end else begin
         mtime <= mtime_nxt;
         if (wr_cmp_lo) mtimecmp[31:0]  <= merge_bytes(mtimecmp[31:0], w_val, w_byte_en);
         if (wr_cmp_hi) mtimecmp[63:32] <= merge_bytes(mtimecmp[63:32], w_val, w_byte_en);
         ctrl_enable <= enable_nxt;
         ctrl_irq_en <= irq_en_nxt;
         pending     <= pending_nxt;
         irq         <= pending_nxt && irq_en_nxt;
         r_hit       <= r_in_win;
         r_val       <= r_in_win ? rd_word : 32'h0;
      end
   end

endmodule

// File: tb/tb_mmio_timer.sv
// tb_mmio_timer: directed table, hand-written corner sequences and a
// randomized run checked against a word-level reference model.
module tb_mmio_timer;

   localparam logic [29:0] BASE = 30'h0400_0000;
`ifdef MMIO_TIMER_PRESCALE_EN
   localparam logic [31:0] PRESC_RB = 32'd3;
   localparam int          PDIV     = 4;
`else
   localparam logic [31:0] PRESC_RB = 32'd0;
   localparam int          PDIV     = 1;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [29:0] r_addr = '0;
   logic [31:0] r_val;
   logic        r_hit;
   logic        w_enable = 1'b0;
   logic [29:0] w_addr = '0;
   logic [31:0] w_val = '0;
   logic [3:0]  w_byte_en = '0;
   logic        irq;

   mmio_timer #(.BASE_WADDR(BASE)) dut (
      .clk(clk), .rst_n(rst_n), .r_addr(r_addr), .r_val(r_val), .r_hit(r_hit),
      .w_enable(w_enable), .w_addr(w_addr), .w_val(w_val), .w_byte_en(w_byte_en),
      .irq(irq)
   );

   always #5 clk = ~clk;

   int n_pass = 0;
   int n_tot  = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tot++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", nm, act, exp);
   endtask

   // ---------------- reference model ----------------
   logic [63:0] m_mtime, m_cmp;
   logic [1:0]  m_ctrl;
   logic        m_pend;
   logic [15:0] m_presc, m_pcnt;
   logic [31:0] m_rval;
   logic        m_rhit, m_irq;

   function automatic logic [31:0] lane_mask(input logic [3:0] be);
      logic [31:0] m;
      for (int i = 0; i < 4; i++) m[8*i +: 8] = {8{be[i]}};
      return m;
   endfunction

   function automatic logic [31:0] m_word(input logic [2:0] k);
      case (k)
         3'd0: return m_mtime[31:0];
         3'd1: return m_mtime[63:32];
         3'd2: return m_cmp[31:0];
         3'd3: return m_cmp[63:32];
         3'd4: return {30'h0, m_ctrl};
         3'd5: return {31'h0, m_pend};
`ifdef MMIO_TIMER_PRESCALE_EN
         3'd6: return {16'h0, m_presc};
`endif
         default: return 32'h0;
      endcase
   endfunction

   always @(posedge clk or negedge rst_n) begin : model
      logic [29:0] ro, wo;
      logic        match, adv, wr, new_pend;
      logic [31:0] mk, wd;
      int          sh;
      if (!rst_n) begin
         m_mtime = 64'h0; m_cmp = '1; m_ctrl = 2'b0; m_pend = 1'b0;
         m_presc = 16'h0; m_pcnt = 16'h0;
         m_rval = 32'h0; m_rhit = 1'b0; m_irq = 1'b0;
      end else begin
         ro     = r_addr - BASE;
         m_rhit = (ro < 30'd8);
         m_rval = m_rhit ? m_word(ro[2:0]) : 32'h0;
         match  = m_ctrl[0] && (m_mtime >= m_cmp);
         adv    = 1'b0;
         if (m_ctrl[0]) begin
`ifdef MMIO_TIMER_PRESCALE_EN
            if (m_pcnt == m_presc) begin adv = 1'b1; m_pcnt = 16'h0; end
            else m_pcnt = m_pcnt + 16'd1;
`else
            adv = 1'b1;
`endif
         end
         wo = w_addr - BASE;
         wr = w_enable && (wo < 30'd8) && (w_byte_en != 4'b0);
         mk = lane_mask(w_byte_en);
         wd = w_val & mk;
         new_pend = m_pend;
         if (wr && wo == 30'd5 && w_byte_en[0] && w_val[0]) new_pend = 1'b0;
         if (match) new_pend = 1'b1;
         if (wr && (wo == 30'd0 || wo == 30'd1)) begin
            sh = (wo == 30'd1) ? 32 : 0;
            m_mtime = (m_mtime & ~({32'h0, mk} << sh)) | ({32'h0, wd} << sh);
         end else begin
            m_mtime = m_mtime + 64'(adv);
         end
         if (wr && wo == 30'd2) m_cmp[31:0]  = (m_cmp[31:0]  & ~mk) | wd;
         if (wr && wo == 30'd3) m_cmp[63:32] = (m_cmp[63:32] & ~mk) | wd;
         if (wr && wo == 30'd4) m_ctrl = (m_ctrl & ~mk[1:0]) | wd[1:0];
`ifdef MMIO_TIMER_PRESCALE_EN
         if (wr && wo == 30'd6) m_presc = (m_presc & ~mk[15:0]) | wd[15:0];
`endif
         m_pend = new_pend;
         m_irq  = m_pend & m_ctrl[1];
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic cyc(input int ro, input int wo, input logic we,
                      input logic [31:0] wv, input logic [3:0] be);
      r_addr = BASE + 30'(ro);
      w_addr = BASE + 30'(wo);
      w_enable = we; w_val = wv; w_byte_en = be;
      @(posedge clk);
      @(negedge clk);
      w_enable = 1'b0;
   endtask

   task automatic rd(input int ro);
      cyc(ro, 0, 1'b0, 32'h0, 4'h0);
   endtask

   task automatic wr(input int wo, input logic [31:0] v, input logic [3:0] be, input int ro);
      cyc(ro, wo, 1'b1, v, be);
   endtask

   typedef struct {
      int          ro;
      logic        we;
      int          wo;
      logic [31:0] wv;
      logic [3:0]  be;
      logic [31:0] ev;
      logic        eh;
   } vec_t;

   vec_t tbl[22];

   initial begin
      int          rro, rwo;
      logic        rwe;
      logic [31:0] rwv;
      logic [3:0]  rbe;

      tbl[0]  = '{0, 1'b0, 0, 32'h0, 4'h0, 32'h0, 1'b1};
      tbl[1]  = '{1, 1'b0, 0, 32'h0, 4'h0, 32'h0, 1'b1};
      tbl[2]  = '{2, 1'b0, 0, 32'h0, 4'h0, 32'hFFFF_FFFF, 1'b1};
      tbl[3]  = '{3, 1'b0, 0, 32'h0, 4'h0, 32'hFFFF_FFFF, 1'b1};
      tbl[4]  = '{4, 1'b0, 0, 32'h0, 4'h0, 32'h0, 1'b1};
      tbl[5]  = '{5, 1'b0, 0, 32'h0, 4'h0, 32'h0, 1'b1};
      tbl[6]  = '{6, 1'b0, 0, 32'h0, 4'h0, 32'h0, 1'b1};
      tbl[7]  = '{7, 1'b0, 0, 32'h0, 4'h0, 32'h0, 1'b1};
      tbl[8]  = '{8, 1'b0, 0, 32'h0, 4'h0, 32'h0, 1'b0};
      tbl[9]  = '{-1, 1'b0, 0, 32'h0, 4'h0, 32'h0, 1'b0};
      tbl[10] = '{2, 1'b1, 2, 32'hAABB_CCDD, 4'b0010, 32'hFFFF_FFFF, 1'b1};
      tbl[11] = '{2, 1'b0, 0, 32'h0, 4'h0, 32'hFFFF_CCFF, 1'b1};
      tbl[12] = '{6, 1'b1, 6, 32'h3, 4'hF, 32'h0, 1'b1};
      tbl[13] = '{6, 1'b0, 0, 32'h0, 4'h0, PRESC_RB, 1'b1};
      tbl[14] = '{7, 1'b1, 7, 32'h1234_5678, 4'hF, 32'h0, 1'b1};
      tbl[15] = '{7, 1'b0, 0, 32'h0, 4'h0, 32'h0, 1'b1};
      tbl[16] = '{2, 1'b1, 2, 32'h0, 4'h0, 32'hFFFF_CCFF, 1'b1};
      tbl[17] = '{2, 1'b1, 2, 32'hFFFF_FFFF, 4'hF, 32'hFFFF_CCFF, 1'b1};
      tbl[18] = '{2, 1'b1, 6, 32'h0, 4'b0011, 32'hFFFF_FFFF, 1'b1};
      tbl[19] = '{6, 1'b0, 0, 32'h0, 4'h0, 32'h0, 1'b1};
      tbl[20] = '{4, 1'b1, 4, 32'hFFFF_FFF0, 4'hF, 32'h0, 1'b1};
      tbl[21] = '{4, 1'b0, 0, 32'h0, 4'h0, 32'h0, 1'b1};

      // reset state
      @(posedge clk);
      @(negedge clk);
      chk("reset r_val", r_val, 32'h0);
      chk("reset r_hit", {31'h0, r_hit}, 32'h0);
      chk("reset irq", {31'h0, irq}, 32'h0);
      rst_n = 1'b1;

      // directed table
      for (int i = 0; i < 22; i++) begin
         cyc(tbl[i].ro, tbl[i].wo, tbl[i].we, tbl[i].wv, tbl[i].be);
         chk($sformatf("tbl%0d r_val", i), r_val, tbl[i].ev);
         chk($sformatf("tbl%0d r_hit", i), {31'h0, r_hit}, {31'h0, tbl[i].eh});
         chk($sformatf("tbl%0d irq", i), {31'h0, irq}, 32'h0);
      end

      // free count for 10 cycles, then disable (write cycle still ticks)
      wr(4, 32'h1, 4'hF, 0);
      repeat (10) rd(0);
      rd(0);
      chk("count10 mtime_lo", r_val, 32'd10);
      chk("count10 irq", {31'h0, irq}, 32'h0);
      wr(4, 32'h0, 4'hF, 0);
      rd(0);
      chk("disable old-enable tick", r_val, 32'd12);
      rd(0);
      chk("disable holds mtime", r_val, 32'd12);

      // carry into mtime_hi, pending and irq, sticky W1C behaviour
      wr(0, 32'hFFFF_FFFE, 4'hF, 0);
      wr(1, 32'h0, 4'hF, 0);
      wr(3, 32'h1, 4'hF, 0);
      wr(2, 32'h0, 4'hF, 0);
      wr(4, 32'h3, 4'hF, 0);
      rd(5);
      chk("carry status0", r_val, 32'h0);
      chk("carry irq0", {31'h0, irq}, 32'h0);
      rd(1);
      chk("carry hi before", r_val, 32'h0);
      chk("carry irq1", {31'h0, irq}, 32'h0);
      rd(1);
      chk("carry hi after", r_val, 32'h1);
      chk("carry irq set", {31'h0, irq}, 32'h1);
      rd(5);
      chk("pending set", r_val, 32'h1);
      wr(5, 32'h1, 4'h1, 5);
      chk("w1c vs set irq", {31'h0, irq}, 32'h1);
      rd(5);
      chk("w1c loses to set", r_val, 32'h1);
      wr(3, 32'hFFFF_FFFF, 4'hF, 5);
      chk("cmp write irq", {31'h0, irq}, 32'h1);
      wr(5, 32'h1, 4'h1, 5);
      chk("w1c pre-write read", r_val, 32'h1);
      chk("w1c clears irq", {31'h0, irq}, 32'h0);
      rd(5);
      chk("w1c clears pending", r_val, 32'h0);
      wr(4, 32'h0, 4'hF, 0);

      // pending without irq_en stays off the irq line
      wr(3, 32'h0, 4'hF, 0);
      wr(2, 32'h0, 4'hF, 0);
      wr(4, 32'h1, 4'hF, 0);
      rd(5);
      rd(5);
      chk("noirq pending", r_val, 32'h1);
      chk("noirq irq", {31'h0, irq}, 32'h0);
      wr(4, 32'h3, 4'hF, 0);
      chk("irq_en raises irq", {31'h0, irq}, 32'h1);
      wr(4, 32'h0, 4'hF, 0);
      chk("irq_en drop", {31'h0, irq}, 32'h0);
      wr(2, 32'hFFFF_FFFF, 4'hF, 0);
      wr(3, 32'hFFFF_FFFF, 4'hF, 0);
      wr(5, 32'h1, 4'h1, 0);
      rd(5);
      chk("disabled w1c", r_val, 32'h0);

      // prescaler cadence
      wr(0, 32'h0, 4'hF, 0);
      wr(1, 32'h0, 4'hF, 0);
      wr(6, 32'h3, 4'hF, 0);
      wr(4, 32'h1, 4'hF, 0);
      for (int i = 1; i <= 7; i++) begin
         rd(0);
         chk($sformatf("presc cycle%0d", i), r_val, 32'((i - 1) / PDIV));
      end
      wr(4, 32'h0, 4'hF, 0);
      rd(0);
      chk("presc final", r_val, 32'(8 / PDIV));

      // mtime write suppresses tick; partial byte write
      wr(6, 32'h0, 4'hF, 0);
      wr(4, 32'h1, 4'hF, 0);
      wr(0, 32'd100, 4'hF, 0);
      rd(0);
      chk("mtime write no tick", r_val, 32'd100);
      rd(0);
      chk("mtime resumes", r_val, 32'd101);
      wr(0, 32'h0000_AB00, 4'b0010, 0);
      rd(0);
      chk("mtime byte write", r_val, 32'h0000_AB66);
      rd(0);
      chk("mtime byte resume", r_val, 32'h0000_AB67);
      wr(4, 32'h0, 4'hF, 0);

      // 64-bit wrap
      wr(0, 32'hFFFF_FFFF, 4'hF, 0);
      wr(1, 32'hFFFF_FFFF, 4'hF, 0);
      wr(4, 32'h1, 4'hF, 0);
      rd(1);
      chk("wrap hi before", r_val, 32'hFFFF_FFFF);
      rd(1);
      chk("wrap hi after", r_val, 32'h0);
      rd(0);
      chk("wrap lo after", r_val, 32'h1);
      wr(4, 32'h0, 4'hF, 0);
      wr(5, 32'h1, 4'h1, 0);

      // randomized run against the model
      for (int i = 0; i < 400; i++) begin
         rro = int'($urandom_range(0, 9));
         if (rro == 9) rro = -1;
         rwe = ($urandom_range(0, 2) == 0);
         rwo = int'($urandom_range(0, 8));
         rwv = $urandom;
         rbe = 4'($urandom);
         if (rwo == 6) rwv = $urandom_range(0, 3);
         cyc(rro, rwo, rwe, rwv, rbe);
         chk($sformatf("rand%0d r_val", i), r_val, m_rval);
         chk($sformatf("rand%0d r_hit", i), {31'h0, r_hit}, {31'h0, m_rhit});
         chk($sformatf("rand%0d irq", i), {31'h0, irq}, {31'h0, m_irq});
      end

      // asynchronous reset mid-operation
      wr(2, 32'h0, 4'hF, 0);
      wr(3, 32'h0, 4'hF, 0);
      wr(4, 32'h3, 4'hF, 0);
      rd(4);
      chk("pre-reset r_val", r_val, 32'h3);
      chk("pre-reset irq", {31'h0, irq}, 32'h1);
      #2 rst_n = 1'b0;
      #1;
      chk("async reset r_val", r_val, 32'h0);
      chk("async reset r_hit", {31'h0, r_hit}, 32'h0);
      chk("async reset irq", {31'h0, irq}, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      wr(2, 32'h55, 4'hF, 3);
      chk("post-reset cmp_hi", r_val, 32'hFFFF_FFFF);
      rd(2);
      chk("first write accepted", r_val, 32'h55);
      rd(0);
      chk("post-reset mtime", r_val, 32'h0);

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
